// File: rtl/execute_reg.sv
// execute_reg: ID->EX pipeline register of the pipelined RV32I core.
// Captures decode-stage control/datapath fields for the Execute stage one cycle later,
// with hazard-unit stall (hold) and flush (NOP bubble) plus a per-entry valid bit.
// Optional feature macro: EXEC_BUBBLE_CNT_EN adds i_CntClr / o_BubbleCnt, a saturating
// count of valid instructions squashed by flush.
module execute_reg #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
`ifdef EXEC_BUBBLE_CNT_EN
   ,
   parameter int unsigned CNT_W      = 16
`endif
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_StallE,
   input  logic                  i_FlushE,
   input  logic                  i_ValidD,
   input  logic                  i_RegWriteD,
   input  logic [1:0]            i_ResultSrcD,
   input  logic                  i_MemWriteD,
   input  logic                  i_JumpD,
   input  logic                  i_BranchD,
   input  logic [2:0]            i_ALUControlD,
   input  logic                  i_ALUSrcD,
   input  logic [XLEN-1:0]       i_RD1D,
   input  logic [XLEN-1:0]       i_RD2D,
   input  logic [XLEN-1:0]       i_PCD,
   input  logic [XLEN-1:0]       i_PCPlus4D,
   input  logic [XLEN-1:0]       i_ImmExtD,
   input  logic [REG_ADDR_W-1:0] i_Rs1D,
   input  logic [REG_ADDR_W-1:0] i_Rs2D,
   input  logic [REG_ADDR_W-1:0] i_RdD,
`ifdef EXEC_BUBBLE_CNT_EN
   input  logic                  i_CntClr,
   output logic [CNT_W-1:0]      o_BubbleCnt,
`endif
   output logic                  o_ValidE,
   output logic                  o_RegWriteE,
   output logic [1:0]            o_ResultSrcE,
   output logic                  o_MemWriteE,
   output logic                  o_JumpE,
   output logic                  o_BranchE,
   output logic [2:0]            o_ALUControlE,
   output logic                  o_ALUSrcE,
   output logic [XLEN-1:0]       o_RD1E,
   output logic [XLEN-1:0]       o_RD2E,
   output logic [XLEN-1:0]       o_PCE,
   output logic [XLEN-1:0]       o_PCPlus4E,
   output logic [XLEN-1:0]       o_ImmExtE,
   output logic [REG_ADDR_W-1:0] o_Rs1E,
   output logic [REG_ADDR_W-1:0] o_Rs2E,
   output logic [REG_ADDR_W-1:0] o_RdE
);

   // One pipeline entry; an all-zero entry is a NOP bubble (no writes, x0 addresses).
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [1:0]            result_src;
      logic                  mem_write;
      logic                  jump;
      logic                  branch;
      logic [2:0]            alu_control;
      logic                  alu_src;
      logic [XLEN-1:0]       rd1;
      logic [XLEN-1:0]       rd2;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       pc_plus4;
      logic [XLEN-1:0]       imm_ext;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
   } ex_entry_t;

   ex_entry_t d_entry_c;
   ex_entry_t e_q;

   // Gather decode-side fields into one entry.
   always_comb begin
      d_entry_c             = '0;
      d_entry_c.valid       = i_ValidD;
      d_entry_c.reg_write   = i_RegWriteD;
      d_entry_c.result_src  = i_ResultSrcD;
      d_entry_c.mem_write   = i_MemWriteD;
      d_entry_c.jump        = i_JumpD;
      d_entry_c.branch      = i_BranchD;
      d_entry_c.alu_control = i_ALUControlD;
      d_entry_c.alu_src     = i_ALUSrcD;
      d_entry_c.rd1         = i_RD1D;
      d_entry_c.rd2         = i_RD2D;
      d_entry_c.pc          = i_PCD;
      d_entry_c.pc_plus4    = i_PCPlus4D;
      d_entry_c.imm_ext     = i_ImmExtD;
      d_entry_c.rs1         = i_Rs1D;
      d_entry_c.rs2         = i_Rs2D;
      d_entry_c.rd          = i_RdD;
   end

   // Entry register: flush beats stall beats load.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         e_q <= '0;
      end else if (i_FlushE) begin
         e_q <= '0;
      end else if (!i_StallE) begin
         e_q <= d_entry_c;
      end
   end

`ifdef EXEC_BUBBLE_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] bubble_cnt_q;

   // Count valid instructions squashed by flush; clear wins, saturate at max.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         bubble_cnt_q <= '0;
      end else if (i_CntClr) begin
         bubble_cnt_q <= '0;
      end else if (i_FlushE && e_q.valid && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
   end

   assign o_BubbleCnt = bubble_cnt_q;
`endif

   assign o_ValidE      = e_q.valid;
   assign o_RegWriteE   = e_q.reg_write;
   assign o_ResultSrcE  = e_q.result_src;
   assign o_MemWriteE   = e_q.mem_write;
   assign o_JumpE       = e_q.jump;
   assign o_BranchE     = e_q.branch;
   assign o_ALUControlE = e_q.alu_control;
   assign o_ALUSrcE     = e_q.alu_src;
   assign o_RD1E        = e_q.rd1;
   assign o_RD2E        = e_q.rd2;
   assign o_PCE         = e_q.pc;
   assign o_PCPlus4E    = e_q.pc_plus4;
   assign o_ImmExtE     = e_q.imm_ext;
   assign o_Rs1E        = e_q.rs1;
   assign o_Rs2E        = e_q.rs2;
   assign o_RdE         = e_q.rd;

endmodule

// File: tb/tb_execute_reg.sv
// tb_execute_reg: directed + randomized check of execute_reg against a reference model.
// Counter checks are compiled in when EXEC_BUBBLE_CNT_EN is defined (counter width 4).
module tb_execute_reg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RAW    = 5;
   localparam int unsigned ENT_W  = 11 + 5*XLEN + 3*RAW;
`ifdef EXEC_BUBBLE_CNT_EN
   localparam int unsigned TB_CNT_W = 4;
   localparam int unsigned CNT_SAT  = (1 << TB_CNT_W) - 1;
`endif

   logic i_Clk = 1'b0;
   logic i_Reset, i_StallE, i_FlushE, i_ValidD, i_RegWriteD, i_MemWriteD;
   logic i_JumpD, i_BranchD, i_ALUSrcD;
   logic [1:0] i_ResultSrcD;
   logic [2:0] i_ALUControlD;
   logic [XLEN-1:0] i_RD1D, i_RD2D, i_PCD, i_PCPlus4D, i_ImmExtD;
   logic [RAW-1:0] i_Rs1D, i_Rs2D, i_RdD;
   logic o_ValidE, o_RegWriteE, o_MemWriteE, o_JumpE, o_BranchE, o_ALUSrcE;
   logic [1:0] o_ResultSrcE;
   logic [2:0] o_ALUControlE;
   logic [XLEN-1:0] o_RD1E, o_RD2E, o_PCE, o_PCPlus4E, o_ImmExtE;
   logic [RAW-1:0] o_Rs1E, o_Rs2E, o_RdE;
`ifdef EXEC_BUBBLE_CNT_EN
   logic i_CntClr;
   logic [TB_CNT_W-1:0] o_BubbleCnt;
   int unsigned exp_cnt;
`endif

   logic [ENT_W-1:0] exp_q;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 i_Clk = ~i_Clk;

   execute_reg #(
      .XLEN(XLEN), .REG_ADDR_W(RAW)
`ifdef EXEC_BUBBLE_CNT_EN
      , .CNT_W(TB_CNT_W)
`endif
   ) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_StallE(i_StallE), .i_FlushE(i_FlushE),
      .i_ValidD(i_ValidD), .i_RegWriteD(i_RegWriteD), .i_ResultSrcD(i_ResultSrcD),
      .i_MemWriteD(i_MemWriteD), .i_JumpD(i_JumpD), .i_BranchD(i_BranchD),
      .i_ALUControlD(i_ALUControlD), .i_ALUSrcD(i_ALUSrcD),
      .i_RD1D(i_RD1D), .i_RD2D(i_RD2D), .i_PCD(i_PCD), .i_PCPlus4D(i_PCPlus4D),
      .i_ImmExtD(i_ImmExtD), .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D), .i_RdD(i_RdD),
`ifdef EXEC_BUBBLE_CNT_EN
      .i_CntClr(i_CntClr), .o_BubbleCnt(o_BubbleCnt),
`endif
      .o_ValidE(o_ValidE), .o_RegWriteE(o_RegWriteE), .o_ResultSrcE(o_ResultSrcE),
      .o_MemWriteE(o_MemWriteE), .o_JumpE(o_JumpE), .o_BranchE(o_BranchE),
      .o_ALUControlE(o_ALUControlE), .o_ALUSrcE(o_ALUSrcE),
      .o_RD1E(o_RD1E), .o_RD2E(o_RD2E), .o_PCE(o_PCE), .o_PCPlus4E(o_PCPlus4E),
      .o_ImmExtE(o_ImmExtE), .o_Rs1E(o_Rs1E), .o_Rs2E(o_Rs2E), .o_RdE(o_RdE)
   );

   // Compare one observed value against its expectation and count the result.
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [ENT_W-1:0] d_vec();
      return {i_ValidD, i_RegWriteD, i_ResultSrcD, i_MemWriteD, i_JumpD, i_BranchD,
              i_ALUControlD, i_ALUSrcD, i_RD1D, i_RD2D, i_PCD, i_PCPlus4D, i_ImmExtD,
              i_Rs1D, i_Rs2D, i_RdD};
   endfunction

   function automatic logic [ENT_W-1:0] q_vec();
      return {o_ValidE, o_RegWriteE, o_ResultSrcE, o_MemWriteE, o_JumpE, o_BranchE,
              o_ALUControlE, o_ALUSrcE, o_RD1E, o_RD2E, o_PCE, o_PCPlus4E, o_ImmExtE,
              o_Rs1E, o_Rs2E, o_RdE};
   endfunction

   task automatic rand_payload();
      i_ValidD      = 1'($urandom_range(0, 1));
      i_RegWriteD   = 1'($urandom_range(0, 1));
      i_ResultSrcD  = 2'($urandom_range(0, 3));
      i_MemWriteD   = 1'($urandom_range(0, 1));
      i_JumpD       = 1'($urandom_range(0, 1));
      i_BranchD     = 1'($urandom_range(0, 1));
      i_ALUControlD = 3'($urandom_range(0, 7));
      i_ALUSrcD     = 1'($urandom_range(0, 1));
      i_RD1D        = $urandom;
      i_RD2D        = $urandom;
      i_PCD         = $urandom;
      i_PCPlus4D    = i_PCD + 32'd4;
      i_ImmExtD     = $urandom;
      i_Rs1D        = RAW'($urandom_range(0, 31));
      i_Rs2D        = RAW'($urandom_range(0, 31));
      i_RdD         = RAW'($urandom_range(0, 31));
   endtask

   // Advance one edge: update the model from the applied inputs, then compare 1ns later.
   task automatic tick(input string tag);
      @(posedge i_Clk);
`ifdef EXEC_BUBBLE_CNT_EN
      if (i_CntClr) exp_cnt = 0;
      else if (i_FlushE && exp_q[ENT_W-1] && exp_cnt < CNT_SAT) exp_cnt = exp_cnt + 1;
`endif
      if (i_FlushE) exp_q = '0;
      else if (!i_StallE) exp_q = d_vec();
      #1;
      check(tag, 256'(q_vec()), 256'(exp_q));
`ifdef EXEC_BUBBLE_CNT_EN
      check({tag, "_cnt"}, 256'(o_BubbleCnt), 256'(exp_cnt));
`endif
   endtask

   initial begin
      i_Reset = 1'b0; i_StallE = 1'b0; i_FlushE = 1'b0;
      rand_payload();
`ifdef EXEC_BUBBLE_CNT_EN
      i_CntClr = 1'b0; exp_cnt = 0;
`endif
      exp_q = '0;
      repeat (2) @(posedge i_Clk);
      #1;
      check("reset_init", 256'(q_vec()), 256'(0));
      i_Reset = 1'b1;

      // Load a few random valid entries, then pulse reset mid-cycle.
      repeat (3) begin
         rand_payload(); i_ValidD = 1'b1; i_RdD = 5'd3;
         tick("preload");
      end
      #2 i_Reset = 1'b0;
      #1;
      check("reset_async", 256'(q_vec()), 256'(0));
`ifdef EXEC_BUBBLE_CNT_EN
      check("reset_cnt", 256'(o_BubbleCnt), 256'(0));
      exp_cnt = 0;
`endif
      exp_q = '0;
      i_Reset = 1'b1;
      // First edge after release behaves as a normal load; stale entry must not return.
      rand_payload(); i_ValidD = 1'b0;
      tick("post_reset");

      // Directed load.
      rand_payload();
      i_RegWriteD = 1'b1; i_ResultSrcD = 2'b01; i_RdD = 5'd7;
      i_RD1D = 32'hDEADBEEF; i_ValidD = 1'b1;
      tick("load");
      check("load_rd", 256'(o_RdE), 256'(7));
      check("load_rd1", 256'(o_RD1E), 256'(32'hDEADBEEF));
      check("load_ctl", 256'({o_ValidE, o_RegWriteE, o_ResultSrcE}), 256'(4'b1101));

      // Stall holds RdE=7 for 3 edges while RdD=9, then 9 appears.
      i_RdD = 5'd9; i_RD1D = 32'h12345678; i_StallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("stall");
         check("stall_rd", 256'(o_RdE), 256'(7));
      end
      i_StallE = 1'b0;
      tick("unstall");
      check("unstall_rd", 256'(o_RdE), 256'(9));

      // Flush + stall: valid entry discarded, bubble loaded.
      i_FlushE = 1'b1; i_StallE = 1'b1;
      tick("flush_stall");
      check("flush_valid", 256'(o_ValidE), 256'(0));
      tick("flush_idem");
      check("flush_idem_all", 256'(q_vec()), 256'(0));
      i_FlushE = 1'b0; i_StallE = 1'b0;

`ifdef EXEC_BUBBLE_CNT_EN
      // Counter: clear, then 20 squashed valid entries saturate at 15.
      i_CntClr = 1'b1; tick("cnt_clr0"); i_CntClr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rand_payload(); i_ValidD = 1'b1; i_FlushE = 1'b0;
         tick("cnt_load");
         i_FlushE = 1'b1;
         tick("cnt_flush");
      end
      check("cnt_sat", 256'(o_BubbleCnt), 256'(15));
      tick("cnt_bubble");
      check("cnt_bubble_hold", 256'(o_BubbleCnt), 256'(15));
      i_FlushE = 1'b0; rand_payload(); i_ValidD = 1'b1;
      tick("cnt_reload");
      i_FlushE = 1'b1; i_CntClr = 1'b1;
      tick("cnt_clr_flush");
      check("cnt_clr_wins", 256'(o_BubbleCnt), 256'(0));
      i_FlushE = 1'b0; i_CntClr = 1'b0;
`endif

      // Randomized traffic with bursty stall/flush.
      for (int i = 0; i < 400; i++) begin
         rand_payload();
         i_StallE = ($urandom_range(0, 3) == 0);
         i_FlushE = ($urandom_range(0, 6) == 0);
`ifdef EXEC_BUBBLE_CNT_EN
         i_CntClr = ($urandom_range(0, 19) == 0);
`endif
         tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
